lap_controller: RTL and testbench



---
 rtl/lap_controller_pkg.sv | 14 +
 rtl/lap_controller_if.sv | 29 ++
 rtl/lap_controller_buffer.sv | 31 +++
 rtl/lap_controller.sv | 123 ++++++++++++
 tb/tb_lap_controller.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/lap_controller_pkg.sv
// Shared constants for the stopwatch lap/split controller: FSM state codes and
// default buffer geometry.
package stopwatch_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_STOP   = 2'd2;
    localparam logic [1:0] S_RECALL = 2'd3;

    localparam int DEPTH_DEFAULT = 8;
    localparam int AW_DEFAULT    = 3;
    localparam int TW_DEFAULT    = 16;

endpackage

// File: rtl/lap_controller_if.sv
// Button/counter/display bundle between the lap controller and its neighbours.
interface lap_controller_if
    import stopwatch_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int TW = TW_DEFAULT
);
    logic          start_pulse;
    logic          lap_pulse;
    logic [TW-1:0] time_in;
    logic          clr;
    logic          count;
    logic          disp_sel;
    logic [TW-1:0] disp_time;
    logic [AW:0]   lap_idx;
    logic [AW:0]   lap_cnt;
    logic          full;

    modport master (
        output start_pulse, lap_pulse, time_in,
        input  clr, count, disp_sel, disp_time, lap_idx, lap_cnt, full
    );

    modport slave (
        input  start_pulse, lap_pulse, time_in,
        output clr, count, disp_sel, disp_time, lap_idx, lap_cnt, full
    );

endinterface

// File: rtl/lap_controller_buffer.sv
// DEPTH x TW lap register file: one synchronous write port, one asynchronous
// read port, cleared to zero by reset.
module lap_buffer
    import stopwatch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = AW_DEFAULT,
    parameter int TW    = TW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [TW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [TW-1:0] rdata_o
);

    logic [TW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lap_controller.sv
// Start/stop + lap/reset sequencer: drives counter clear/enable, captures lap
// times into lap_buffer and selects live or recalled time for the display.
module lap_controller
    import stopwatch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = AW_DEFAULT,
    parameter int TW    = TW_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    lap_controller_if.slave  bus
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [1:0]    state_q, state_d;
    logic          clr_q, clr_d;
    logic          count_q, count_d;
    logic          disp_sel_q, disp_sel_d;
    logic [AW:0]   lap_idx_q, lap_idx_d;
    logic [AW:0]   lap_cnt_q, lap_cnt_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          we;
    logic [TW-1:0] rdata;
    logic          last_lap;

    assign last_lap = ({1'b0, rd_ptr_q} + 1'b1) >= lap_cnt_q;

    always_comb begin
        state_d   = state_q;
        lap_cnt_d = lap_cnt_q;
        rd_ptr_d  = rd_ptr_q;
        we        = 1'b0;
        // start_pulse has priority: a coincident lap_pulse is dropped.
        case (state_q)
            S_IDLE: begin
                if (bus.start_pulse) begin
                    state_d   = S_RUN;
                    lap_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (bus.start_pulse) begin
                    state_d = S_STOP;
                end else if (bus.lap_pulse && lap_cnt_q != CNT_FULL) begin
                    we        = 1'b1;
                    lap_cnt_d = lap_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bus.start_pulse) begin
                    state_d = S_RUN;
                end else if (bus.lap_pulse) begin
                    state_d  = (lap_cnt_q != '0) ? S_RECALL : S_IDLE;
                    rd_ptr_d = '0;
                end
            end
            default: begin
                if (bus.start_pulse) begin
                    state_d  = S_STOP;
                    rd_ptr_d = '0;
                end else if (bus.lap_pulse) begin
                    if (last_lap) begin
                        state_d   = S_IDLE;
                        lap_cnt_d = '0;
                        rd_ptr_d  = '0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
        endcase

        clr_d      = (state_d == S_IDLE);
        count_d    = (state_d == S_RUN);
        disp_sel_d = (state_d == S_RECALL);
        lap_idx_d  = (state_d == S_RECALL) ? ({1'b0, rd_ptr_d} + 1'b1) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            clr_q      <= 1'b1;
            count_q    <= 1'b0;
            disp_sel_q <= 1'b0;
            lap_idx_q  <= '0;
            lap_cnt_q  <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            clr_q      <= clr_d;
            count_q    <= count_d;
            disp_sel_q <= disp_sel_d;
            lap_idx_q  <= lap_idx_d;
            lap_cnt_q  <= lap_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    lap_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .TW    (TW)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .we_i    (we),
        .waddr_i (lap_cnt_q[AW-1:0]),
        .wdata_i (bus.time_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    assign bus.clr       = clr_q;
    assign bus.count     = count_q;
    assign bus.disp_sel  = disp_sel_q;
    assign bus.lap_idx   = lap_idx_q;
    assign bus.lap_cnt   = lap_cnt_q;
    assign bus.full      = (lap_cnt_q == CNT_FULL);
    assign bus.disp_time = disp_sel_q ? rdata : bus.time_in;

endmodule

// File: tb/tb_lap_controller.sv
// Bench for lap_controller: directed scenarios followed by random button
// traffic, all compared against a queue-based model of the stopwatch.
module tb_lap_controller;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int TW    = 16;

    localparam int M_IDLE   = 10;
    localparam int M_RUN    = 11;
    localparam int M_STOP   = 12;
    localparam int M_RECALL = 13;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lap_controller_if #(.AW(AW), .TW(TW)) bus ();

    lap_controller #(.DEPTH(DEPTH), .AW(AW), .TW(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int            m_mode;
    logic [TW-1:0] m_laps[$];
    int            m_ridx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_laps.delete();
        m_ridx = 0;
    endtask

    task automatic model_step(input bit s, input bit l, input logic [TW-1:0] t);
        case (m_mode)
            M_IDLE: if (s) begin m_mode = M_RUN; m_laps.delete(); end
            M_RUN: begin
                if (s) m_mode = M_STOP;
                else if (l && m_laps.size() < DEPTH) m_laps.push_back(t);
            end
            M_STOP: begin
                if (s) m_mode = M_RUN;
                else if (l) begin
                    if (m_laps.size() > 0) begin m_mode = M_RECALL; m_ridx = 0; end
                    else m_mode = M_IDLE;
                end
            end
            default: begin
                if (s) begin m_mode = M_STOP; m_ridx = 0; end
                else if (l) begin
                    if (m_ridx + 1 < m_laps.size()) m_ridx++;
                    else begin m_mode = M_IDLE; m_laps.delete(); m_ridx = 0; end
                end
            end
        endcase
    endtask

    task automatic check_model(input string tag);
        logic [TW-1:0] exp_disp;
        int            exp_idx;
        exp_disp = (m_mode == M_RECALL) ? m_laps[m_ridx] : bus.time_in;
        exp_idx  = (m_mode == M_RECALL) ? m_ridx + 1 : 0;
        chk({tag, ".clr"},       32'(bus.clr),       32'(m_mode == M_IDLE));
        chk({tag, ".count"},     32'(bus.count),     32'(m_mode == M_RUN));
        chk({tag, ".disp_sel"},  32'(bus.disp_sel),  32'(m_mode == M_RECALL));
        chk({tag, ".lap_idx"},   32'(bus.lap_idx),   32'(exp_idx));
        chk({tag, ".lap_cnt"},   32'(bus.lap_cnt),   32'(m_laps.size()));
        chk({tag, ".full"},      32'(bus.full),      32'(m_laps.size() == DEPTH));
        chk({tag, ".disp_time"}, 32'(bus.disp_time), 32'(exp_disp));
    endtask

    task automatic cycle(input string tag, input bit s, input bit l, input logic [TW-1:0] t);
        bus.start_pulse = s;
        bus.lap_pulse   = l;
        bus.time_in     = t;
        @(posedge clk);
        model_step(s, l, t);
        #1;
        check_model(tag);
        bus.start_pulse = 1'b0;
        bus.lap_pulse   = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_model(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_model({tag, ".rel"});
    endtask

    initial begin
        logic [TW-1:0] t;
        bit            s, l;

        reset           = 1'b1;
        bus.start_pulse = 1'b0;
        bus.lap_pulse   = 1'b0;
        bus.time_in     = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        reset = 1'b0;

        // Start/stop basics, then STOP with no laps falls back to IDLE.
        cycle("start", 1, 0, 16'h0000);
        chk("start.count_const", 32'(bus.count), 32'd1);
        cycle("stop", 1, 0, 16'h0042);
        chk("stop.count_const", 32'(bus.count), 32'd0);
        cycle("stop_lap0", 0, 1, 16'h0042);
        chk("stop_lap0.clr_const", 32'(bus.clr), 32'd1);

        // Two laps, then recall them in order.
        cycle("run2", 1, 0, 16'h0000);
        cycle("lap1", 0, 1, 16'h0123);
        cycle("lap2", 0, 1, 16'h0457);
        cycle("stop2", 1, 0, 16'h0500);
        cycle("rec1", 0, 1, 16'h0500);
        chk("rec1.disp_const", 32'(bus.disp_time), 32'h0123);
        chk("rec1.idx_const", 32'(bus.lap_idx), 32'd1);
        cycle("rec2", 0, 1, 16'h0500);
        chk("rec2.disp_const", 32'(bus.disp_time), 32'h0457);
        cycle("rec_end", 0, 1, 16'h0500);
        chk("rec_end.cnt_const", 32'(bus.lap_cnt), 32'd0);

        // Fill past capacity; the ninth lap must be ignored.
        cycle("run3", 1, 0, 16'h0000);
        for (int i = 1; i <= DEPTH + 1; i++) begin
            cycle("fill", 0, 1, {4'(i), 4'h1, 4'h2, 4'(i)});
            if (i == DEPTH) chk("fill.full_const", 32'(bus.full), 32'd1);
        end
        cycle("stop3", 1, 0, 16'h0900);
        for (int i = 0; i < DEPTH; i++) cycle("rec_fill", 0, 1, 16'h0900);
        chk("rec_fill.last_const", 32'(bus.disp_time), 32'h8128);
        cycle("rec_fill_end", 0, 1, 16'h0900);

        // Coincident pulses in RUN: start wins.
        cycle("run4", 1, 0, 16'h0000);
        cycle("lap4", 0, 1, 16'h0311);
        cycle("both", 1, 1, 16'h0322);
        chk("both.cnt_const", 32'(bus.lap_cnt), 32'd1);

        // RECALL left by start returns to STOP with index cleared.
        cycle("rec5", 0, 1, 16'h0330);
        cycle("rec5_start", 1, 0, 16'h0330);
        chk("rec5_start.idx_const", 32'(bus.lap_idx), 32'd0);

        // Build three laps, recall the third, then reset mid-recall.
        cycle("resume6", 1, 0, 16'h0330);
        cycle("lap6a", 0, 1, 16'h0401);
        cycle("lap6b", 0, 1, 16'h0402);
        cycle("stop6", 1, 0, 16'h0403);
        for (int i = 0; i < 3; i++) cycle("rec6", 0, 1, 16'h0403);
        chk("rec6.idx_const", 32'(bus.lap_idx), 32'd3);
        async_reset("rst_recall");

        // Random button traffic with occasional asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            s = ($urandom % 6) == 0;
            l = ($urandom % 3) == 0;
            t = TW'($urandom);
            cycle("rand", s, l, t);
            if (i % 400 == 399) async_reset("rand_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

endmodule
